s386w_resp_misr: RTL and testbench

- Downstream response compactor for the s386w controller benchmark.
- Consumes the 7 next-state/output bits v13_D_6..v13_D_12 beat by beat and folds them into a 16-bit Galois MISR signature.
- After a programmed number of samples, compares the signature against an expected value and reports pass/fail.
- Sits between the s386w instance and the testbench/BIST controller; replaces per-cycle output checking with a single end-of-run compare.

---
 rtl/s386w_resp_misr.sv | 212 +++++++++++++++++++++
 tb/tb_s386w_resp_misr.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/s386w_resp_misr.sv
// Response compactor for the s386w benchmark: folds the 7 next-state/output bits
// into a 16-bit Galois MISR and compares the result against a golden signature.

module s386w_resp_misr #(
    parameter int                 RESP_W      = 7,
    parameter int                 SIG_W       = 16,
    parameter int                 CNT_W       = 16,
    parameter logic [SIG_W-1:0]   POLY        = 16'h1021,
    parameter logic [SIG_W-1:0]   SEED        = 16'hFFFF,
    parameter int                 SKIP_CYCLES = 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [SIG_W-1:0]  expected_sig,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  sample_count,
    output logic              pass,
    output logic              fail
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SKIP_INIT = CNT_W'(SKIP_CYCLES);

    // One Galois MISR step: shift, conditional polynomial feedback, fold in the beat.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0]  sig,
        input logic [RESP_W-1:0] data
    );
        logic [SIG_W-1:0] fb;
        fb        = sig[SIG_W-1] ? POLY : {SIG_W{1'b0}};
        misr_step = (sig << 1) ^ fb ^ {{(SIG_W-RESP_W){1'b0}}, data};
    endfunction

    state_t            state_r, state_s;
    logic [SIG_W-1:0]  sig_r, sig_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic [CNT_W-1:0]  skip_r, skip_s;
    logic [CNT_W-1:0]  num_r, num_s;
    logic [SIG_W-1:0]  exp_r, exp_s;
    logic              pass_r, pass_s;
    logic              fail_r, fail_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    // Next-state, datapath and verdict logic; the verdict is computed on entry to
    // DONE so pass/fail are already valid during the done pulse.
    always_comb begin
        state_s = state_r;
        sig_s   = sig_r;
        count_s = count_r;
        skip_s  = skip_r;
        num_s   = num_r;
        exp_s   = exp_r;
        pass_s  = pass_r;
        fail_s  = fail_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    num_s   = num_patterns;
                    exp_s   = expected_sig;
                    sig_s   = SEED;
                    count_s = CNT_ZERO;
                    pass_s  = 1'b0;
                    fail_s  = 1'b0;
                    if (num_patterns == CNT_ZERO) begin
                        state_s = ST_DONE;
                        pass_s  = (SEED == expected_sig);
                        fail_s  = (SEED != expected_sig);
                    end else if (SKIP_INIT == CNT_ZERO) begin
                        state_s = ST_CAPTURE;
                    end else begin
                        state_s = ST_SKIP;
                        skip_s  = SKIP_INIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SKIP: begin
                if (resp_valid) begin
                    skip_s = skip_r - CNT_ONE;
                    if (skip_r == CNT_ONE) begin
                        state_s = ST_CAPTURE;
                    end else begin
                        state_s = ST_SKIP;
                    end
                end else begin
                    state_s = ST_SKIP;
                end
            end

            ST_CAPTURE: begin
                if (resp_valid) begin
                    sig_s   = misr_step(sig_r, resp_data);
                    count_s = count_r + CNT_ONE;
                    if (count_s == num_r) begin
                        state_s = ST_DONE;
                        pass_s  = (sig_s == exp_r);
                        fail_s  = (sig_s != exp_r);
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end else begin
                    state_s = ST_CAPTURE;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s == ST_SKIP) || (state_s == ST_CAPTURE);
        done_s = (state_s == ST_DONE);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            sig_r   <= SEED;
            count_r <= CNT_ZERO;
            skip_r  <= CNT_ZERO;
            num_r   <= CNT_ZERO;
            exp_r   <= {SIG_W{1'b0}};
            pass_r  <= 1'b0;
            fail_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sig_r   <= sig_s;
            count_r <= count_s;
            skip_r  <= skip_s;
            num_r   <= num_s;
            exp_r   <= exp_s;
            pass_r  <= pass_s;
            fail_r  <= fail_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign signature    = sig_r;
    assign sample_count = count_r;
    assign pass         = pass_r;
    assign fail         = fail_r;

    s386w_resp_misr_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .busy         (busy_r),
        .done         (done_r),
        .pass         (pass_r),
        .fail         (fail_r),
        .sample_count (count_r),
        .num_latched  (num_r)
    );

endmodule

// Protocol invariants of the compactor's registered outputs.
module s386w_resp_misr_chk #(
    parameter int CNT_W = 16
) (
    input logic             CLOCK,
    input logic             RESET,
    input logic             busy,
    input logic             done,
    input logic             pass,
    input logic             fail,
    input logic [CNT_W-1:0] sample_count,
    input logic [CNT_W-1:0] num_latched
);

    a_verdict_exclusive: assert property (@(posedge CLOCK) disable iff (RESET)
        !(pass && fail));

    a_done_not_busy: assert property (@(posedge CLOCK) disable iff (RESET)
        done |-> !busy);

    a_done_single: assert property (@(posedge CLOCK) disable iff (RESET)
        done |=> !done);

    a_count_bounded: assert property (@(posedge CLOCK) disable iff (RESET)
        sample_count <= num_latched);

endmodule

// File: tb/tb_s386w_resp_misr.sv
// Directed bench for s386w_resp_misr: a vector table for the basic runs plus
// hand-written sequences for restart-ignore, async reset abort and idle traffic.

module tb_s386w_resp_misr;

    logic        CLOCK;
    logic        RESET;
    logic        start;
    logic [15:0] num_patterns;
    logic [15:0] expected_sig;
    logic        resp_valid;
    logic [6:0]  resp_data;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [15:0] sample_count;
    logic        pass;
    logic        fail;

    int total;
    int bad;

    typedef struct {
        logic        start;
        logic [15:0] n;
        logic [15:0] exp;
        logic        valid;
        logic [6:0]  data;
        logic        busy;
        logic        done;
        logic [15:0] sig;
        logic [15:0] cnt;
        logic        pass;
        logic        fail;
    } vec_t;

    vec_t vt[15];

    s386w_resp_misr dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .start        (start),
        .num_patterns (num_patterns),
        .expected_sig (expected_sig),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .busy         (busy),
        .done         (done),
        .signature    (signature),
        .sample_count (sample_count),
        .pass         (pass),
        .fail         (fail)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    function automatic vec_t mk(
        input logic st, input logic [15:0] n, input logic [15:0] ex,
        input logic v, input logic [6:0] d,
        input logic b, input logic dn, input logic [15:0] s, input logic [15:0] c,
        input logic p, input logic f
    );
        vec_t r;
        r.start = st; r.n = n; r.exp = ex; r.valid = v; r.data = d;
        r.busy = b; r.done = dn; r.sig = s; r.cnt = c; r.pass = p; r.fail = f;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic check_outs(input string tag, input logic b, input logic dn,
                              input logic [15:0] s, input logic [15:0] c,
                              input logic p, input logic f);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        check({tag, "_done"}, {31'd0, done}, {31'd0, dn});
        check({tag, "_sig"},  {16'd0, signature}, {16'd0, s});
        check({tag, "_cnt"},  {16'd0, sample_count}, {16'd0, c});
        check({tag, "_pass"}, {31'd0, pass}, {31'd0, p});
        check({tag, "_fail"}, {31'd0, fail}, {31'd0, f});
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic drive_step(input logic st, input logic [15:0] n, input logic [15:0] ex,
                              input logic v, input logic [6:0] d);
        start        = st;
        num_patterns = n;
        expected_sig = ex;
        resp_valid   = v;
        resp_data    = d;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Run 1: N=1, skip 0x55, capture 0x7F -> 0xEFA0, pass.
        vt[0]  = mk(1'b1, 16'd1, 16'hEFA0, 1'b0, 7'h00, 1'b1, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0);
        vt[1]  = mk(1'b0, 16'd1, 16'hEFA0, 1'b1, 7'h55, 1'b1, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0);
        vt[2]  = mk(1'b0, 16'd1, 16'hEFA0, 1'b1, 7'h7F, 1'b0, 1'b1, 16'hEFA0, 16'd1, 1'b1, 1'b0);
        vt[3]  = mk(1'b0, 16'd1, 16'hEFA0, 1'b0, 7'h00, 1'b0, 1'b0, 16'hEFA0, 16'd1, 1'b1, 1'b0);
        // Run 2: N=2, zeros with a 3-cycle gap -> 0xEFDF then 0xCF9F, fail.
        vt[4]  = mk(1'b1, 16'd2, 16'h0000, 1'b0, 7'h00, 1'b1, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0);
        vt[5]  = mk(1'b0, 16'd2, 16'h0000, 1'b1, 7'h00, 1'b1, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0);
        vt[6]  = mk(1'b0, 16'd2, 16'h0000, 1'b1, 7'h00, 1'b1, 1'b0, 16'hEFDF, 16'd1, 1'b0, 1'b0);
        vt[7]  = mk(1'b0, 16'd2, 16'h0000, 1'b0, 7'h7F, 1'b1, 1'b0, 16'hEFDF, 16'd1, 1'b0, 1'b0);
        vt[8]  = mk(1'b0, 16'd2, 16'h0000, 1'b0, 7'h2A, 1'b1, 1'b0, 16'hEFDF, 16'd1, 1'b0, 1'b0);
        vt[9]  = mk(1'b0, 16'd2, 16'h0000, 1'b0, 7'h11, 1'b1, 1'b0, 16'hEFDF, 16'd1, 1'b0, 1'b0);
        vt[10] = mk(1'b0, 16'd2, 16'h0000, 1'b1, 7'h00, 1'b0, 1'b1, 16'hCF9F, 16'd2, 1'b0, 1'b1);
        vt[11] = mk(1'b0, 16'd2, 16'h0000, 1'b0, 7'h00, 1'b0, 1'b0, 16'hCF9F, 16'd2, 1'b0, 1'b1);
        // Run 3: N=0 -> done next cycle, no busy; a start during DONE is ignored.
        vt[12] = mk(1'b1, 16'd0, 16'hFFFF, 1'b1, 7'h33, 1'b0, 1'b1, 16'hFFFF, 16'd0, 1'b1, 1'b0);
        vt[13] = mk(1'b1, 16'd5, 16'h1234, 1'b1, 7'h44, 1'b0, 1'b0, 16'hFFFF, 16'd0, 1'b1, 1'b0);
        vt[14] = mk(1'b0, 16'd5, 16'h1234, 1'b1, 7'h44, 1'b0, 1'b0, 16'hFFFF, 16'd0, 1'b1, 1'b0);

        start        = 1'b0;
        num_patterns = 16'd0;
        expected_sig = 16'd0;
        resp_valid   = 1'b0;
        resp_data    = 7'd0;
        RESET        = 1'b1;
        repeat (2) @(posedge CLOCK);
        #1;
        check_outs("reset", 1'b0, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0);
        RESET = 1'b0;

        // Idle traffic without start must leave everything untouched.
        for (int i = 0; i < 8; i++) begin
            drive_step(1'b0, 16'd3, 16'h0000, 1'b1, 7'($urandom_range(0, 127)));
            check_outs($sformatf("idle%0d", i), 1'b0, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 15; i++) begin
            drive_step(vt[i].start, vt[i].n, vt[i].exp, vt[i].valid, vt[i].data);
            check_outs($sformatf("row%0d", i), vt[i].busy, vt[i].done, vt[i].sig,
                       vt[i].cnt, vt[i].pass, vt[i].fail);
        end

        // N=4 zero beats -> 0x0E1F; restart with N=9 mid-capture is ignored.
        drive_step(1'b1, 16'd4, 16'h0E1F, 1'b0, 7'h00);
        check_outs("r4_start", 1'b1, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0);
        drive_step(1'b0, 16'd4, 16'h0E1F, 1'b1, 7'h00);
        drive_step(1'b0, 16'd4, 16'h0E1F, 1'b1, 7'h00);
        check_outs("r4_b1", 1'b1, 1'b0, 16'hEFDF, 16'd1, 1'b0, 1'b0);
        drive_step(1'b1, 16'd9, 16'h0000, 1'b1, 7'h00);
        check_outs("r4_b2", 1'b1, 1'b0, 16'hCF9F, 16'd2, 1'b0, 1'b0);
        drive_step(1'b0, 16'd9, 16'h0000, 1'b1, 7'h00);
        check_outs("r4_b3", 1'b1, 1'b0, 16'h8F1F, 16'd3, 1'b0, 1'b0);
        drive_step(1'b0, 16'd9, 16'h0000, 1'b1, 7'h00);
        check_outs("r4_b4", 1'b0, 1'b1, 16'h0E1F, 16'd4, 1'b1, 1'b0);
        drive_step(1'b0, 16'd9, 16'h0000, 1'b0, 7'h00);
        check_outs("r4_after", 1'b0, 1'b0, 16'h0E1F, 16'd4, 1'b1, 1'b0);

        // Async reset after 2 of 4 captured beats aborts without a done pulse.
        drive_step(1'b1, 16'd4, 16'h0E1F, 1'b0, 7'h00);
        drive_step(1'b0, 16'd4, 16'h0E1F, 1'b1, 7'h00);
        drive_step(1'b0, 16'd4, 16'h0E1F, 1'b1, 7'h00);
        drive_step(1'b0, 16'd4, 16'h0E1F, 1'b1, 7'h00);
        check_outs("r5_mid", 1'b1, 1'b0, 16'hCF9F, 16'd2, 1'b0, 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        check_outs("r5_rst", 1'b0, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0);
        drive_step(1'b0, 16'd4, 16'h0E1F, 1'b1, 7'h00);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_step(1'b0, 16'd4, 16'h0E1F, 1'b1, 7'h00);
            check_outs($sformatf("r5_quiet%0d", i), 1'b0, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0);
        end
        drive_step(1'b1, 16'd1, 16'hEFA0, 1'b0, 7'h00);
        drive_step(1'b0, 16'd1, 16'hEFA0, 1'b1, 7'h55);
        drive_step(1'b0, 16'd1, 16'hEFA0, 1'b1, 7'h7F);
        check_outs("r5_fresh", 1'b0, 1'b1, 16'hEFA0, 16'd1, 1'b1, 1'b0);
        drive_step(1'b0, 16'd1, 16'hEFA0, 1'b0, 7'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
